shift_rotate_engine: RTL

SHIFT_ROTATE_ENGINE -- requirements
Module: shift_rotate_engine

---
 rtl/shift_pkg.sv | 32 +++
 rtl/shift_step.sv | 51 +++++
 rtl/shift_rotate_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate engine: op encoding, FSM states,
// amount width and a helper that folds reserved op codes onto LSL.
package shift_pkg;

  localparam int AMT_W = 8;

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Codes 5..7 have no operation of their own and behave as LSL.
  function automatic op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    decode_op = OP_LSR;
      3'd2:    decode_op = OP_ASR;
      3'd3:    decode_op = OP_ROR;
      3'd4:    decode_op = OP_RRX;
      default: decode_op = OP_LSL;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP positions. A zero shift
// passes the incoming carry through untouched.
module shift_step
  import shift_pkg::*;
#(
  parameter int BUS  = 32,
  parameter int STEP = 8,
  localparam int SW  = $clog2(STEP + 1)
) (
  input  logic [BUS-1:0] data,
  input  op_e            op,
  input  logic [SW-1:0]  shamt,
  input  logic           carry_in,
  output logic [BUS-1:0] data_out,
  output logic           carry_out
);

  logic [BUS:0] ext;

  // Extend by one guard bit so the last bit shifted out lands in a known place.
  always_comb begin
    ext       = '0;
    data_out  = data;
    carry_out = carry_in;
    case (op)
      OP_LSR: begin
        ext      = {data, 1'b0} >> shamt;
        data_out = ext[BUS:1];
        if (shamt != '0) carry_out = ext[0];
      end
      OP_ASR: begin
        ext      = $signed({data, 1'b0}) >>> shamt;
        data_out = ext[BUS:1];
        if (shamt != '0) carry_out = ext[0];
      end
      OP_ROR: begin
        data_out = (data >> shamt) | (data << (BUS - int'(shamt)));
        if (shamt != '0) carry_out = data_out[BUS-1];
      end
      OP_RRX: begin
        data_out = data;
      end
      default: begin
        ext      = {1'b0, data} << shamt;
        data_out = ext[BUS-1:0];
        if (shamt != '0) carry_out = ext[BUS];
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate_engine.sv
// Multi-cycle barrel shifter: accepts one request, shifts at most STEP bits
// per clock, then holds the result until the consumer takes it.
module shift_rotate_engine
  import shift_pkg::*;
#(
  parameter int BUS  = 32,
  parameter int STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS-1:0]   a,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS-1:0]   result,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(BUS + 1);
  localparam int SW    = $clog2(STEP + 1);

  state_e           state;
  op_e              op_r;
  logic [BUS-1:0]   data_r;
  logic             carry_r;
  logic [CNT_W-1:0] remaining;

  op_e              op_dec;
  logic [CNT_W-1:0] acc_rem;
  logic [BUS-1:0]   acc_data;
  logic             acc_carry;

  logic [SW-1:0]    step_amt;
  logic [BUS-1:0]   step_data;
  logic             step_carry;

  // Resolve the effective amount and settle the zero-cycle special cases at accept time.
  always_comb begin
    op_dec    = decode_op(op);
    acc_rem   = '0;
    acc_data  = a;
    acc_carry = carry_in;
    case (op_dec)
      OP_RRX: begin
        acc_data  = {carry_in, a[BUS-1:1]};
        acc_carry = a[0];
      end
      OP_ASR: begin
        acc_rem = (int'(amt) >= BUS) ? CNT_W'(BUS) : CNT_W'(amt);
      end
      OP_ROR: begin
        acc_rem = CNT_W'(int'(amt) % BUS);
        if (amt != '0 && acc_rem == '0) acc_carry = a[BUS-1];
      end
      default: begin
        if (int'(amt) > BUS) begin
          acc_data  = '0;
          acc_carry = 1'b0;
        end else begin
          acc_rem = CNT_W'(amt);
        end
      end
    endcase
  end

  // Each shift cycle consumes up to STEP positions of the remaining amount.
  always_comb begin
    step_amt = (remaining > CNT_W'(STEP)) ? SW'(STEP) : SW'(remaining);
  end

  shift_step #(
    .BUS  (BUS),
    .STEP (STEP)
  ) u_step (
    .data      (data_r),
    .op        (op_r),
    .shamt     (step_amt),
    .carry_in  (carry_r),
    .data_out  (step_data),
    .carry_out (step_carry)
  );

  // Request/shift/hold sequencing; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_r      <= OP_LSL;
      data_r    <= '0;
      carry_r   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r      <= op_dec;
            data_r    <= acc_data;
            carry_r   <= acc_carry;
            remaining <= acc_rem;
            state     <= (acc_rem != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_r    <= step_data;
          carry_r   <= step_carry;
          remaining <= remaining - CNT_W'(step_amt);
          if (remaining <= CNT_W'(step_amt)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = data_r;
  assign carry_out = carry_r;

endmodule
